// File: rtl/axis_tx_pkt_stamp.sv
// Packet stamper: prefixes each tlast-delimited AXI-Stream packet with {MAGIC, seq}.
// Define AXIS_TX_PKT_STAMP_TRAILER_EN to append a byte-count trailer word after each packet.
module axis_tx_pkt_stamp #(
  parameter logic [15:0] MAGIC    = 16'hA55A,
  parameter logic [15:0] SEQ_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tlast,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tlast,
  output logic [15:0] o_seq
);

  typedef enum logic [1:0] {IDLE, BODY, TRL} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  keep_q, keep_d;
  logic        last_q, last_d;
  logic [15:0] seq_q, seq_d;
  logic        slot_free;

`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
  logic [31:0] cnt_q, cnt_d;

  function automatic logic [2:0] popcnt4(input logic [3:0] k);
    return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free = !valid_q || o_tready;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q && !o_tready;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    seq_d    = seq_q;
    i_tready = 1'b0;
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_tvalid && slot_free) begin
          valid_d = 1'b1;
          data_d  = {MAGIC, seq_q};
          keep_d  = 4'hF;
          last_d  = 1'b0;
          state_d = BODY;
        end
      end
      BODY: begin
        i_tready = slot_free;
        if (i_tvalid && slot_free) begin
          valid_d = 1'b1;
          data_d  = i_tdata;
          keep_d  = i_tkeep;
          last_d  = 1'b0;
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
          cnt_d   = cnt_q + 32'(popcnt4(i_tkeep));
          if (i_tlast) state_d = TRL;
`else
          if (i_tlast) begin
            last_d  = 1'b1;
            seq_d   = seq_q + 16'd1;
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
      TRL: begin
        if (slot_free) begin
          valid_d = 1'b1;
          data_d  = cnt_q;
          keep_d  = 4'hF;
          last_d  = 1'b1;
          seq_d   = seq_q + 16'd1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      seq_q   <= SEQ_INIT;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
    end
  end

`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign o_tvalid = valid_q;
  assign o_tdata  = data_q;
  assign o_tkeep  = keep_q;
  assign o_tlast  = last_q;
  assign o_seq    = seq_q;

endmodule

// File: tb/tb_axis_tx_pkt_stamp.sv
// Self-checking bench for axis_tx_pkt_stamp; a second instance with SEQ_INIT=16'hFFFF covers sequence wrap.
module tb_axis_tx_pkt_stamp;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tvalid = 1'b0;
  logic [31:0] i_tdata = '0;
  logic [3:0]  i_tkeep = '0;
  logic        i_tlast = 1'b0;
  logic        o_tready = 1'b1;
  logic        i_tready, o_tvalid, o_tlast;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep;
  logic [15:0] o_seq;
  logic        i_tready2, o_tvalid2, o_tlast2;
  logic [31:0] o_tdata2;
  logic [3:0]  o_tkeep2;
  logic [15:0] o_seq2;

  int checks = 0;
  int errors = 0;
  int gap_max = 0;
  logic [31:0] pd[$];
  logic [3:0]  pk[$];
  beat_t exp1[$], exp2[$], cap1[$], cap2[$];
  logic [15:0] mseq = 16'h0000;

  always #5 clk = ~clk;

  axis_tx_pkt_stamp dut (
    .clk(clk), .rst(rst), .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast), .o_tready(o_tready), .o_tvalid(o_tvalid),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_seq(o_seq)
  );

  axis_tx_pkt_stamp #(.MAGIC(16'hA55A), .SEQ_INIT(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .i_tready(i_tready2), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast), .o_tready(o_tready), .o_tvalid(o_tvalid2),
    .o_tdata(o_tdata2), .o_tkeep(o_tkeep2), .o_tlast(o_tlast2), .o_seq(o_seq2)
  );

  // Record every completed output transfer of both instances.
  always @(negedge clk) begin
    if (o_tvalid && o_tready)  cap1.push_back({o_tdata, o_tkeep, o_tlast});
    if (o_tvalid2 && o_tready) cap2.push_back({o_tdata2, o_tkeep2, o_tlast2});
  end

  // Reference: header, body verbatim, optional byte-count trailer; seq advances per packet.
  task automatic model_pkt();
    logic [31:0] bytes = 0;
    logic [15:0] seq2 = mseq + 16'hFFFF;
    exp1.push_back({16'hA55A, mseq, 4'hF, 1'b0});
    exp2.push_back({16'hA55A, seq2, 4'hF, 1'b0});
    for (int i = 0; i < pd.size(); i++) begin
      bytes = bytes + 32'($countones(pk[i]));
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
      exp1.push_back({pd[i], pk[i], 1'b0});
      exp2.push_back({pd[i], pk[i], 1'b0});
`else
      exp1.push_back({pd[i], pk[i], i == pd.size() - 1});
      exp2.push_back({pd[i], pk[i], i == pd.size() - 1});
`endif
    end
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
    exp1.push_back({bytes, 4'hF, 1'b1});
    exp2.push_back({bytes, 4'hF, 1'b1});
`endif
    mseq = mseq + 16'd1;
  endtask

  task automatic drive_pkt();
    int t;
    model_pkt();
    for (int i = 0; i < pd.size(); i++) begin
      if (gap_max > 0) begin
        i_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
      i_tvalid = 1'b1;
      i_tdata  = pd[i];
      i_tkeep  = pk[i];
      i_tlast  = (i == pd.size() - 1);
      t = 0;
      @(negedge clk);
      while (!i_tready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
        errors++;
        $display("FAIL accept_timeout beat=%0d got i_tready=0 need 1", i);
      end
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((cap1.size() < exp1.size() || cap2.size() < exp2.size()) && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats need %0d", cap1.size(), exp1.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
    o_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mseq = 16'h0000;
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%h k=%h l=%0b rdy=%0b need all 0",
               o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready);
    end
    checks++;
    if (o_seq !== 16'h0000 || o_seq2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_seq got %h/%h need 0000/ffff", o_seq, o_seq2);
    end
  endtask

  task automatic test_basic();
    pd = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    pk = '{4'hF, 4'hF, 4'h3};
    drive_pkt();
    wait_drain();
    checks++;
    if (cap1.size() !== exp1.size()) begin
      errors++;
      $display("FAIL basic_count got %0d need %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %h need %h", i, cap1[i], exp1[i]);
      end
    end
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
    checks++;
    if (cap1.size() != 5 || cap1[4] !== {32'h0000000A, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL basic_trailer got %0d beats need trailer 0000000a", cap1.size());
    end
`endif
    checks++;
    if (o_seq !== 16'h0001) begin
      errors++;
      $display("FAIL basic_seq got %h need 0001", o_seq);
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pd = '{32'hC0DE0000 + 32'(p)};
      pk = '{4'hF};
      drive_pkt();
    end
    wait_drain();
    checks++;
    if (cap1.size() !== exp1.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d need %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h need %h", i, cap1[i], exp1[i]);
      end
    end
    checks++;
    if (o_seq !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_seq got %h need 0002", o_seq);
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_stall();
    logic done = 1'b0;
    logic [3:0] pat = 4'b1001;
    do_reset();
    pd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    pk = '{4'hF, 4'hF, 4'hF, 4'h7};
    fork
      begin
        drive_pkt();
        wait_drain();
        done = 1'b1;
      end
      begin
        int c = 0;
        while (!done) begin
          @(posedge clk); #1;
          o_tready = pat[3 - (c % 4)];
          c++;
        end
        o_tready = 1'b1;
      end
      begin
        logic stalled = 1'b0;
        logic [37:0] held = '0;
        while (!done) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== held) begin
              errors++;
              $display("FAIL stall_hold got %h need %h", {o_tvalid, o_tdata, o_tkeep, o_tlast}, held);
            end
          end
          stalled = o_tvalid && !o_tready;
          held = {o_tvalid, o_tdata, o_tkeep, o_tlast};
        end
      end
    join
    @(posedge clk); #1;
    checks++;
    if (cap1.size() !== exp1.size()) begin
      errors++;
      $display("FAIL stall_count got %0d need %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL stall_beat%0d got %h need %h", i, cap1[i], exp1[i]);
      end
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      pd = '{32'h0BADF00D ^ 32'(p), 32'h12345678};
      pk = '{4'hF, 4'hC};
      drive_pkt();
    end
    wait_drain();
    checks++;
    if (cap2.size() !== exp2.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d need %0d", cap2.size(), exp2.size());
    end
    for (int i = 0; i < exp2.size() && i < cap2.size(); i++) begin
      checks++;
      if (cap2[i] !== exp2[i]) begin
        errors++;
        $display("FAIL wrap_beat%0d got %h need %h", i, cap2[i], exp2[i]);
      end
    end
    checks++;
    if (cap2.size() < 1 || cap2[0].d !== 32'hA55AFFFF || o_seq2 !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_header got seq=%h need first header a55affff and seq 0001", o_seq2);
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_tvalid = 1'b1;
    i_tdata  = 32'hDEADBEEF;
    i_tkeep  = 4'hF;
    i_tlast  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready} !== 39'd0 || o_seq !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_outputs got v=%0b d=%h k=%h l=%0b rdy=%0b seq=%h need all 0",
               o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready, o_seq);
    end
    @(posedge clk); #1 rst = 1'b0;
    mseq = 16'h0000;
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
    pd = '{32'h01020304, 32'h05060708};
    pk = '{4'hF, 4'h1};
    drive_pkt();
    wait_drain();
    checks++;
    if (cap1.size() !== exp1.size()) begin
      errors++;
      $display("FAIL midrst_count got %0d need %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL midrst_beat%0d got %h need %h", i, cap1[i], exp1[i]);
      end
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_keep_zero();
    do_reset();
    pd = '{32'hFFFFFFFF, 32'h000000AB, 32'hCAFEBABE};
    pk = '{4'h0, 4'h1, 4'hF};
    drive_pkt();
    wait_drain();
    checks++;
    if (cap1.size() !== exp1.size()) begin
      errors++;
      $display("FAIL keep0_count got %0d need %0d", cap1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL keep0_beat%0d got %h need %h", i, cap1[i], exp1[i]);
      end
    end
`ifdef AXIS_TX_PKT_STAMP_TRAILER_EN
    checks++;
    if (cap1.size() != 5 || cap1[4].d !== 32'h00000005) begin
      errors++;
      $display("FAIL keep0_trailer got %0d beats need trailer 00000005", cap1.size());
    end
`endif
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  task automatic test_random();
    logic done = 1'b0;
    do_reset();
    gap_max = 2;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          int n = $urandom_range(1, 6);
          pd.delete(); pk.delete();
          for (int b = 0; b < n; b++) begin
            pd.push_back($urandom);
            pk.push_back(4'($urandom));
          end
          drive_pkt();
        end
        wait_drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          o_tready = ($urandom_range(0, 9) < 7);
        end
        o_tready = 1'b1;
      end
    join
    gap_max = 0;
    @(posedge clk); #1;
    checks++;
    if (cap1.size() !== exp1.size() || cap2.size() !== exp2.size()) begin
      errors++;
      $display("FAIL rand_count got %0d/%0d need %0d/%0d", cap1.size(), cap2.size(), exp1.size(), exp2.size());
    end
    for (int i = 0; i < exp1.size() && i < cap1.size() && i < cap2.size(); i++) begin
      checks++;
      if (cap1[i] !== exp1[i] || cap2[i] !== exp2[i]) begin
        errors++;
        $display("FAIL rand_beat%0d got %h/%h need %h/%h", i, cap1[i], cap2[i], exp1[i], exp2[i]);
      end
    end
    checks++;
    if (o_seq !== mseq || o_seq2 !== mseq + 16'hFFFF) begin
      errors++;
      $display("FAIL rand_seq got %h/%h need %h/%h", o_seq, o_seq2, mseq, mseq + 16'hFFFF);
    end
    exp1.delete(); exp2.delete(); cap1.delete(); cap2.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_seq_wrap();
    test_reset_mid();
    test_keep_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
